// File: rtl/mac_layer_sequencer_pkg.sv
// Shared state encoding and width helpers for the MAC layer sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    CLEAR,
    COMPUTE,
    DRAIN,
    DONE
  } seq_state_t;

  // One extra bit so the terminal value TERM-1 always fits without relying on wrap.
  function automatic int beat_cnt_w(input int term);
    return $clog2(term) + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_layer_sequencer_beat_counter.sv
// Handshake beat counter that wraps after TERM beats; last_beat flags the terminal beat.
module mac_beat_counter
  import mac_seq_pkg::*;
#(
  parameter int TERM  = 64,
  parameter int CNT_W = beat_cnt_w(TERM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             beat,
  output logic [CNT_W-1:0] count,
  output logic             last_beat
);

  logic [CNT_W-1:0] count_reg;

  assign count     = count_reg;
  assign last_beat = beat && (count_reg == CNT_W'(TERM - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count_reg <= '0;
    end else if (beat) begin
      count_reg <= last_beat ? '0 : count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mac_layer_sequencer.sv
// Sequences weight loading and per-vector clear/compute/drain passes for the MAC datapath.
module mac_layer_sequencer
  import mac_seq_pkg::*;
#(
  parameter int HIDDEN_UNITS = 64,
  parameter int INPUT_DIM    = 64,
  parameter int VEC_CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    skip_weights,
  input  logic [VEC_CNT_W-1:0]    num_vectors,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic                    in_ready,
  input  logic                    in_last,
  output logic                    in_gate,
  input  logic                    out_valid,
  input  logic                    out_ready,
  output logic                    load_w,
  output logic [HIDDEN_UNITS-1:0] load_vector,
  output logic                    clear,
  output logic                    busy,
  output logic                    done,
  output logic                    err_tlast,
  output logic [VEC_CNT_W-1:0]    vec_idx
);

  localparam int IN_CNT_W  = beat_cnt_w(INPUT_DIM);
  localparam int OUT_CNT_W = beat_cnt_w(HIDDEN_UNITS);
  localparam int UNIT_W    = idx_w(HIDDEN_UNITS);

  seq_state_t            state_reg, state_next;
  logic [UNIT_W-1:0]     unit_idx_reg;
  logic [VEC_CNT_W-1:0]  vec_idx_reg, num_vec_reg;
  logic                  err_tlast_reg;
  logic [IN_CNT_W-1:0]   in_count;
  logic [OUT_CNT_W-1:0]  out_count;
  logic                  in_beat, out_beat, in_last_beat, out_last_beat;
  logic                  in_cnt_clr, out_cnt_clr;
  logic                  start_ok, unit_last, vec_last;
  logic                  count_unused;

  assign in_beat     = in_valid & in_ready & in_gate;
  assign out_beat    = out_valid & out_ready & (state_reg == DRAIN);
  assign start_ok    = start & ~abort & (state_reg == IDLE);
  assign unit_last   = (unit_idx_reg == UNIT_W'(HIDDEN_UNITS - 1));
  assign vec_last    = (vec_idx_reg == num_vec_reg - VEC_CNT_W'(1));
  assign in_cnt_clr  = abort | ~((state_reg == LOAD_W) | (state_reg == COMPUTE));
  assign out_cnt_clr = abort | (state_reg != DRAIN);
  // Decisions use last_beat only; the raw counts are kept for observability.
  assign count_unused = ^{in_count, out_count};

  assign err_tlast = err_tlast_reg;
  assign vec_idx   = vec_idx_reg;

  mac_beat_counter #(.TERM(INPUT_DIM)) u_in_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (in_cnt_clr),
    .beat      (in_beat),
    .count     (in_count),
    .last_beat (in_last_beat)
  );

  mac_beat_counter #(.TERM(HIDDEN_UNITS)) u_out_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (out_cnt_clr),
    .beat      (out_beat),
    .count     (out_count),
    .last_beat (out_last_beat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (start) state_next = skip_weights ? CLEAR : LOAD_W;
        LOAD_W:  if (in_last_beat && unit_last) state_next = CLEAR;
        CLEAR:   state_next = COMPUTE;
        COMPUTE: if (in_last_beat) state_next = DRAIN;
        DRAIN:   if (out_last_beat) state_next = vec_last ? DONE : CLEAR;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_gate = 1'b0;
    load_w  = 1'b0;
    clear   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_reg)
      IDLE:    busy = 1'b0;
      LOAD_W:  begin load_w = 1'b1; in_gate = 1'b1; end
      CLEAR:   clear = 1'b1;
      COMPUTE: in_gate = 1'b1;
      DRAIN:   ;
      DONE:    begin busy = 1'b0; done = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < HIDDEN_UNITS; gi++) begin : g_load_vec
      assign load_vector[gi] = (state_reg == LOAD_W) && (unit_idx_reg == UNIT_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      unit_idx_reg  <= '0;
      vec_idx_reg   <= '0;
      num_vec_reg   <= '0;
      err_tlast_reg <= 1'b0;
    end else if (abort) begin
      // The TLAST error stays visible so the host can inspect it after an abort.
      unit_idx_reg <= '0;
      vec_idx_reg  <= '0;
      num_vec_reg  <= '0;
    end else begin
      if (start_ok) begin
        num_vec_reg   <= (num_vectors == '0) ? VEC_CNT_W'(1) : num_vectors;
        err_tlast_reg <= 1'b0;
        unit_idx_reg  <= '0;
        vec_idx_reg   <= '0;
      end
      if ((state_reg == LOAD_W) && in_last_beat && !unit_last) begin
        unit_idx_reg <= unit_idx_reg + UNIT_W'(1);
      end
      if (out_last_beat && !vec_last) begin
        vec_idx_reg <= vec_idx_reg + VEC_CNT_W'(1);
      end
      if (in_beat && (in_last != in_last_beat)) begin
        err_tlast_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Directed bench for mac_layer_sequencer with HIDDEN_UNITS=4, INPUT_DIM=8.
module tb_mac_layer_sequencer;

  localparam int HU = 4;
  localparam int ID = 8;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, skip_weights = 1'b0, abort = 1'b0;
  logic [VW-1:0] num_vectors = '0;
  logic          in_valid = 1'b0, in_ready = 1'b0, in_last = 1'b0;
  logic          out_valid = 1'b0, out_ready = 1'b0;
  logic          in_gate, load_w, clear, busy, done, err_tlast;
  logic [HU-1:0] load_vector;
  logic [VW-1:0] vec_idx;

  int n_cmp = 0;
  int n_mis = 0;

  int r_in, r_out, r_clear, r_done, r_loadw, r_lv_err, r_vi_err, r_gate_err;
  int r_last_ob, r_done_cyc, r_err_beat_cyc, r_err_first, r_vec_at_done;
  int r_busy_at_done, r_err_after_start;
  bit r_timeout, r_aborted;

  always #5 clk = ~clk;

  mac_layer_sequencer #(
    .HIDDEN_UNITS (HU),
    .INPUT_DIM    (ID),
    .VEC_CNT_W    (VW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .skip_weights (skip_weights),
    .num_vectors  (num_vectors),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_gate      (in_gate),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .load_w       (load_w),
    .load_vector  (load_vector),
    .clear        (clear),
    .busy         (busy),
    .done         (done),
    .err_tlast    (err_tlast),
    .vec_idx      (vec_idx)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Caller is always 1 time unit after a rising edge with the DUT in IDLE.
  task automatic run_seq(input string name, input bit skip, input int nv_cmd, input int pin,
                         input int pout, input int err_beat, input int abort_at, input bit busy_start);
    int  w_total, dbeats;
    bit  drain, ib, ob, bs_done;
    w_total = skip ? 0 : HU * ID;
    r_in = 0; r_out = 0; r_clear = 0; r_done = 0; r_loadw = 0;
    r_lv_err = 0; r_vi_err = 0; r_gate_err = 0;
    r_last_ob = -1; r_done_cyc = -1; r_err_beat_cyc = -1; r_err_first = -1;
    r_vec_at_done = -1; r_busy_at_done = -1; r_aborted = 0; bs_done = 0;
    start = 1'b1; skip_weights = skip; num_vectors = VW'(nv_cmd);
    @(posedge clk); #1;
    start = 1'b0; skip_weights = 1'b0; num_vectors = VW'(7);
    r_err_after_start = int'(err_tlast);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      dbeats = r_in - w_total;
      drain  = (r_in >= w_total) && (dbeats == ID * (r_out / HU + 1));
      if (abort_at >= 0 && r_in >= w_total && dbeats == abort_at) begin
        in_valid = 1'b0; out_valid = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; r_aborted = 1;
        break;
      end
      in_valid  = ($urandom_range(99) < pin);
      in_ready  = 1'b1;
      in_last   = ((r_in % ID) == ID - 1) ^ (r_in == err_beat);
      out_valid = drain;
      out_ready = ($urandom_range(99) < pout);
      start     = busy_start && drain && !bs_done;
      if (start) begin skip_weights = 1'b1; num_vectors = VW'(9); end
      @(negedge clk);
      if (start) bs_done = 1;
      ib = in_valid & in_ready & in_gate;
      ob = out_valid & out_ready;
      if (clear) r_clear++;
      if (clear && in_gate) r_gate_err++;
      if (drain && in_gate) r_gate_err++;
      if (load_w) r_loadw++;
      if (err_tlast && r_err_first < 0) r_err_first = cyc;
      if (ib) begin
        if (r_in < w_total) begin
          if (!load_w || load_vector != HU'(1 << (r_in / ID))) r_lv_err++;
        end else if (load_w || load_vector != '0) begin
          r_lv_err++;
        end
        if (r_in == err_beat) r_err_beat_cyc = cyc;
        r_in++;
      end
      if (ob) begin
        if (int'(vec_idx) != r_out / HU) r_vi_err++;
        r_out++;
        r_last_ob = cyc;
      end
      if (done) begin
        r_done++; r_done_cyc = cyc;
        r_vec_at_done = int'(vec_idx); r_busy_at_done = int'(busy);
      end
      @(posedge clk); #1;
      start = 1'b0; skip_weights = 1'b0;
      if (r_done > 0) break;
    end
    in_valid = 1'b0; out_valid = 1'b0; in_last = 1'b0;
    r_timeout = (r_done == 0) && !r_aborted;
    $display("run %s: in_beats=%0d out_beats=%0d clears=%0d dones=%0d load_w_cycles=%0d err_tlast=%0d",
             name, r_in, r_out, r_clear, r_done, r_loadw, err_tlast);
  endtask

  // exp_loadw < 0 means only a lower bound of the weight beat count applies (stalled runs).
  task automatic check_run(input string name, input int nv, input bit skip, input bit exp_err,
                           input int exp_loadw);
    int w_total;
    w_total = skip ? 0 : HU * ID;
    check_val({name, " timeout"}, r_timeout, 0);
    check_val({name, " done_count"}, r_done, 1);
    check_val({name, " clear_count"}, r_clear, nv);
    check_val({name, " in_beats"}, r_in, w_total + ID * nv);
    check_val({name, " out_beats"}, r_out, HU * nv);
    check_val({name, " load_vector_err"}, r_lv_err, 0);
    check_val({name, " vec_idx_err"}, r_vi_err, 0);
    check_val({name, " gate_err"}, r_gate_err, 0);
    check_val({name, " done_latency"}, r_done_cyc - r_last_ob, 1);
    check_val({name, " vec_idx_at_done"}, r_vec_at_done, nv - 1);
    check_val({name, " busy_at_done"}, r_busy_at_done, 0);
    check_val({name, " err_tlast_end"}, err_tlast, exp_err);
    if (exp_loadw >= 0) check_val({name, " load_w_cycles"}, r_loadw, exp_loadw);
    else check_val({name, " load_w_min"}, r_loadw >= w_total, 1);
  endtask

  initial begin
    int dones_after;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_ctrl", {busy, done, load_w, in_gate, clear, err_tlast}, 0);
    check_val("reset_load_vector", load_vector, 0);
    check_val("reset_vec_idx", vec_idx, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("idle_busy", busy, 0);

    run_seq("full", 1'b0, 2, 100, 100, -1, -1, 1'b0);
    check_run("full", 2, 1'b0, 1'b0, HU * ID);

    run_seq("tlast", 1'b0, 1, 100, 100, 2 * ID + 5, -1, 1'b0);
    check_run("tlast", 1, 1'b0, 1'b1, HU * ID);
    check_val("tlast err_latency", r_err_first - r_err_beat_cyc, 1);

    run_seq("skip", 1'b1, 0, 100, 100, -1, -1, 1'b0);
    check_val("skip err_cleared_by_start", r_err_after_start, 0);
    check_run("skip", 1, 1'b1, 1'b0, 0);

    run_seq("backpressure", 1'b0, 2, 50, 50, -1, -1, 1'b1);
    check_run("backpressure", 2, 1'b0, 1'b0, -1);

    run_seq("abort", 1'b0, 1, 100, 100, -1, 3, 1'b0);
    check_val("abort reached", r_aborted, 1);
    check_val("abort ctrl", {busy, load_w, in_gate, clear, done}, 0);
    check_val("abort vec_idx", vec_idx, 0);
    dones_after = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) dones_after++;
    end
    @(posedge clk); #1;
    check_val("abort no_done", dones_after, 0);

    run_seq("post_abort", 1'b1, 1, 100, 100, -1, -1, 1'b0);
    check_run("post_abort", 1, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mac_layer_sequencer.md
Name: mac_layer_sequencer

Overview:
- Hardware sequencer for the MAC accelerator datapath; replaces host-driven AXI-Lite toggling of load_w / load_vector / clear.
- On one start command it:
  - loads weights into every hidden unit in order, one unit per INPUT_DIM-beat input burst;
  - then runs num_vectors inference passes, each one clear, one INPUT_DIM-beat compute burst and one HIDDEN_UNITS-beat output drain.
- Sits between the control register block and the MAC datapath. It observes the input/output stream handshakes and gates the input stream.

Parameters:
- HIDDEN_UNITS, 64, number of MAC units; width of the load_vector one-hot.
- INPUT_DIM, 64, beats per weight row and per input vector.
- VEC_CNT_W, 16, width of the num_vectors field and the vector counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  single-cycle command pulse; accepted only in IDLE.
- skip_weights  in  1  sampled with start; 1 = keep stored weights and go straight to CLEAR.
- num_vectors  in  VEC_CNT_W  vectors to process; sampled at start; 0 is treated as 1.
- abort  in  1  synchronous abort, effective from any state.
- in_valid  in  1  input stream TVALID (before gating).
- in_ready  in  1  input stream TREADY from the datapath.
- in_last  in  1  input stream TLAST.
- in_gate  out  1  input stream enable; upstream TVALID/TREADY are ANDed with it.
- out_valid  in  1  output stream TVALID.
- out_ready  in  1  output stream TREADY.
- load_w  out  1  weight-load mode to the datapath.
- load_vector  out  HIDDEN_UNITS  one-hot select of the unit being loaded.
- clear  out  1  single-cycle accumulator clear.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse on completion.
- err_tlast  out  1  sticky: in_last disagreed with the beat count.
- vec_idx  out  VEC_CNT_W  index of the vector currently in progress.

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0.
- Beat definitions:
  - in_beat = in_valid & in_ready & in_gate.
  - out_beat = out_valid & out_ready.
- States and transitions:
  - IDLE:
    - start → LOAD_W, or → CLEAR if skip_weights=1.
    - On start: latch num_vectors (0 becomes 1), clear err_tlast, unit_idx=0, vec_idx=0.
  - LOAD_W:
    - Outputs: load_w=1, load_vector=1<<unit_idx, in_gate=1.
    - Counts in_beat up to INPUT_DIM-1.
    - On the final beat: if unit_idx=HIDDEN_UNITS-1 → CLEAR; otherwise unit_idx++ and the beat counter wraps to 0.
    - load_vector changes on the cycle after the final beat. There are no gap cycles.
  - CLEAR:
    - Exactly 1 cycle; clear=1, in_gate=0, load_w=0, load_vector=0.
    - Always → COMPUTE.
  - COMPUTE:
    - in_gate=1, load_w=0.
    - Counts in_beat; the final (INPUT_DIM-th) beat → DRAIN.
  - DRAIN:
    - in_gate=0.
    - Counts out_beat; the HIDDEN_UNITS-th beat →
      - DONE if vec_idx=num_vectors-1;
      - otherwise vec_idx++ and → CLEAR.
  - DONE:
    - 1 cycle; done=1, busy=0.
    - → IDLE.
- TLAST check:
  - Applies to every in_beat in LOAD_W and COMPUTE.
  - Error condition: in_last=1 on a non-final beat, or in_last=0 on the final beat.
  - Effect: err_tlast sets and holds until the next accepted start.
  - The sequence continues on beat count only; there is no early termination.
- Stalls: counters advance only on handshake beats. Arbitrary valid/ready gaps are allowed in every counting state.
- Ignored start:
  - start while busy is ignored; it produces no error and no state change.
  - start coincident with abort is ignored.
- Abort:
  - Next cycle: state IDLE, all control outputs 0, counters 0.
  - done is not pulsed. err_tlast is retained.
- Gating: in_gate=0 outside LOAD_W and COMPUTE. No input beat can be consumed during CLEAR, DRAIN, DONE or IDLE.
- Counter widths:
  - Beat counter: $clog2(INPUT_DIM)+1 bits.
  - unit_idx: $clog2(HIDDEN_UNITS) bits.
  - Out-beat counter: $clog2(HIDDEN_UNITS)+1 bits.
  - Comparisons are against the constants -1; no wrap-around is relied upon.

Decomposition:
- Package mac_seq_pkg:
  - state enum {IDLE, LOAD_W, CLEAR, COMPUTE, DRAIN, DONE};
  - width localparam functions derived from HIDDEN_UNITS and INPUT_DIM.
- Sub-module mac_beat_counter: parameterized terminal count; inputs clr and beat; outputs count and last_beat (combinational, true when count=TERM-1 and beat). Instantiated twice, for input beats and output beats.

Test Plan (HIDDEN_UNITS=4, INPUT_DIM=8):
- Full run:
  - Stimulus: start with num_vectors=2, skip_weights=0; 32 weight beats, then 8 data beats per vector; out_ready=1.
  - Response: load_vector steps 0001 → 0010 → 0100 → 1000, changing every 8 beats; then clear pulses exactly twice; 4 drain beats per vector; done pulses once after the 8th out_beat; err_tlast=0.
- Skip weights:
  - Stimulus: start with skip_weights=1, num_vectors=0.
  - Response: load_w never asserted; one CLEAR cycle, 8 compute beats, 4 drain beats; done fires; vec_idx stays 0.
- Backpressure:
  - Stimulus: random in_valid/out_ready at 50% duty.
  - Response: same transition sequence as the full run; counters advance only on handshakes; in_gate=0 throughout DRAIN.
- TLAST error:
  - Stimulus: in_last asserted on beat 5 of unit 2 weights.
  - Response: err_tlast=1 from the next cycle; sequence still completes with done; the next start clears err_tlast.
- Abort:
  - Stimulus: abort during COMPUTE beat 3.
  - Response: next cycle busy=0, load_w=0, in_gate=0, no done pulse. A following start with skip_weights=1 completes normally.
- Start while busy:
  - Stimulus: start pulsed during DRAIN.
  - Response: ignored; vec_idx and the latched num_vectors are unchanged.
